// File: rtl/cu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cu_pkg
// Brief    : State encoding, opcode map and ALU operation codes shared by the
//            multicycle control unit and its opcode decoder.
// Revision : 1.0
// ============================================================================
package cu_pkg;

    typedef enum logic [2:0] {
        FETCH   = 3'd0,
        DECODE  = 3'd1,
        EXEC    = 3'd2,
        MEM     = 3'd3,
        WB      = 3'd4,
        WAIT_IN = 3'd5,
        HALT    = 3'd6
    } state_t;

    // Instruction class: selects the path the FSM takes after EXEC
    typedef enum logic [3:0] {
        K_ALU     = 4'd0,
        K_LOAD    = 4'd1,
        K_STORE   = 4'd2,
        K_IN      = 4'd3,
        K_BEQ     = 4'd4,
        K_BNE     = 4'd5,
        K_JUMP    = 4'd6,
        K_OUT     = 4'd7,
        K_RESET   = 4'd8,
        K_HALT    = 4'd9,
        K_ILLEGAL = 4'd10
    } op_kind_t;

    localparam logic [5:0] c_OP_ADD   = 6'h00;
    localparam logic [5:0] c_OP_SUB   = 6'h01;
    localparam logic [5:0] c_OP_AND   = 6'h02;
    localparam logic [5:0] c_OP_OR    = 6'h03;
    localparam logic [5:0] c_OP_XOR   = 6'h04;
    localparam logic [5:0] c_OP_SLT   = 6'h05;
    localparam logic [5:0] c_OP_MUL   = 6'h06;
    localparam logic [5:0] c_OP_DIV   = 6'h07;
    localparam logic [5:0] c_OP_REM   = 6'h08;
    localparam logic [5:0] c_OP_BEQ   = 6'h09;
    localparam logic [5:0] c_OP_BNE   = 6'h0A;
    localparam logic [5:0] c_OP_ADDI  = 6'h0B;
    localparam logic [5:0] c_OP_SUBI  = 6'h0C;
    localparam logic [5:0] c_OP_INC   = 6'h0D;
    localparam logic [5:0] c_OP_DEC   = 6'h0E;
    localparam logic [5:0] c_OP_LW    = 6'h0F;
    localparam logic [5:0] c_OP_SW    = 6'h10;
    localparam logic [5:0] c_OP_NOT   = 6'h11;
    localparam logic [5:0] c_OP_SLL   = 6'h12;
    localparam logic [5:0] c_OP_SRL   = 6'h13;
    localparam logic [5:0] c_OP_LWI   = 6'h14;
    localparam logic [5:0] c_OP_IN    = 6'h15;
    localparam logic [5:0] c_OP_OUT   = 6'h16;
    localparam logic [5:0] c_OP_JUMP  = 6'h17;
    localparam logic [5:0] c_OP_HALT  = 6'h18;
    localparam logic [5:0] c_OP_RESET = 6'h19;

    localparam logic [3:0] c_ALU_NONE = 4'd0;
    localparam logic [3:0] c_ALU_ADD  = 4'd1;
    localparam logic [3:0] c_ALU_SUB  = 4'd2;
    localparam logic [3:0] c_ALU_INC  = 4'd3;
    localparam logic [3:0] c_ALU_DEC  = 4'd4;
    localparam logic [3:0] c_ALU_AND  = 4'd5;
    localparam logic [3:0] c_ALU_OR   = 4'd6;
    localparam logic [3:0] c_ALU_XOR  = 4'd7;
    localparam logic [3:0] c_ALU_NOT  = 4'd8;
    localparam logic [3:0] c_ALU_SLL  = 4'd9;
    localparam logic [3:0] c_ALU_SRL  = 4'd10;
    localparam logic [3:0] c_ALU_SLT  = 4'd11;
    localparam logic [3:0] c_ALU_MUL  = 4'd12;
    localparam logic [3:0] c_ALU_DIV  = 4'd13;
    localparam logic [3:0] c_ALU_REM  = 4'd14;
    localparam logic [3:0] c_ALU_PASS = 4'd15;

endpackage
`default_nettype wire

// File: rtl/multicycle_control_if.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_control_if
// Brief    : Status inputs and control outputs between the control unit
//            (master) and the datapath/environment (slave).
// Revision : 1.0
// ============================================================================
interface multicycle_control_if #(
    parameter int OP_W    = 6,
    parameter int ALUOP_W = 4
);
    logic [OP_W-1:0]    opcode;
    logic               zero;
    logic               mem_ready;
    logic               in_valid;
    logic               resume;

    logic               cu_writeReg;
    logic               cu_regDest;
    logic               cu_memtoReg;
    logic               cu_Jump;
    logic               cu_inSignal;
    logic               cu_aluScr;
    logic               cu_writeEnable;
    logic               cu_readEnable;
    logic               cu_Branch;
    logic               cu_hlt;
    logic               cu_reset;
    logic               cu_showDisplay;
    logic               cu_pcWrite;
    logic               cu_irWrite;
    logic               cu_illegal;
    logic [ALUOP_W-1:0] cu_aluOp;
    logic [2:0]         cu_state;

    modport master (
        input  opcode, zero, mem_ready, in_valid, resume,
        output cu_writeReg, cu_regDest, cu_memtoReg, cu_Jump, cu_inSignal,
               cu_aluScr, cu_writeEnable, cu_readEnable, cu_Branch, cu_hlt,
               cu_reset, cu_showDisplay, cu_pcWrite, cu_irWrite, cu_illegal,
               cu_aluOp, cu_state
    );

    modport slave (
        output opcode, zero, mem_ready, in_valid, resume,
        input  cu_writeReg, cu_regDest, cu_memtoReg, cu_Jump, cu_inSignal,
               cu_aluScr, cu_writeEnable, cu_readEnable, cu_Branch, cu_hlt,
               cu_reset, cu_showDisplay, cu_pcWrite, cu_irWrite, cu_illegal,
               cu_aluOp, cu_state
    );
endinterface
`default_nettype wire

// File: rtl/cu_alu_decode.sv
`default_nettype none
// ============================================================================
// Module   : cu_alu_decode
// Brief    : Combinational opcode decode: ALU op, operand/destination selects
//            and the instruction class steering the FSM.
// Revision : 1.0
// ============================================================================
module cu_alu_decode
    import cu_pkg::*;
#(
    parameter int OP_W    = 6,
    parameter int ALUOP_W = 4
) (
    input  wire logic [OP_W-1:0]    i_opcode,
    output logic      [ALUOP_W-1:0] o_alu_op,
    output logic                    o_alu_src,
    output logic                    o_reg_dest,
    output op_kind_t                o_kind
);
    logic       w_hi_nz;
    logic [5:0] w_op6;
    logic [3:0] w_alu;

    assign w_op6 = i_opcode[5:0];

    // Any set bit above the 6-bit opcode map makes the opcode undefined
    if (OP_W > 6) begin : g_wide
        assign w_hi_nz = |i_opcode[OP_W-1:6];
    end else begin : g_exact
        assign w_hi_nz = 1'b0;
    end

    always_comb begin
        w_alu      = c_ALU_NONE;
        o_alu_src  = 1'b0;
        o_reg_dest = 1'b0;
        o_kind     = K_ILLEGAL;
        if (!w_hi_nz) begin
            case (w_op6)
                c_OP_ADD:   begin w_alu = c_ALU_ADD;  o_reg_dest = 1'b1; o_kind = K_ALU; end
                c_OP_SUB:   begin w_alu = c_ALU_SUB;  o_reg_dest = 1'b1; o_kind = K_ALU; end
                c_OP_AND:   begin w_alu = c_ALU_AND;  o_reg_dest = 1'b1; o_kind = K_ALU; end
                c_OP_OR:    begin w_alu = c_ALU_OR;   o_reg_dest = 1'b1; o_kind = K_ALU; end
                c_OP_XOR:   begin w_alu = c_ALU_XOR;  o_reg_dest = 1'b1; o_kind = K_ALU; end
                c_OP_SLT:   begin w_alu = c_ALU_SLT;  o_reg_dest = 1'b1; o_kind = K_ALU; end
                c_OP_MUL:   begin w_alu = c_ALU_MUL;  o_reg_dest = 1'b1; o_kind = K_ALU; end
                c_OP_DIV:   begin w_alu = c_ALU_DIV;  o_reg_dest = 1'b1; o_kind = K_ALU; end
                c_OP_REM:   begin w_alu = c_ALU_REM;  o_reg_dest = 1'b1; o_kind = K_ALU; end
                c_OP_NOT:   begin w_alu = c_ALU_NOT;  o_reg_dest = 1'b1; o_kind = K_ALU; end
                c_OP_ADDI:  begin w_alu = c_ALU_ADD;  o_alu_src  = 1'b1; o_kind = K_ALU; end
                c_OP_SUBI:  begin w_alu = c_ALU_SUB;  o_alu_src  = 1'b1; o_kind = K_ALU; end
                c_OP_INC:   begin w_alu = c_ALU_INC;  o_alu_src  = 1'b1; o_kind = K_ALU; end
                c_OP_DEC:   begin w_alu = c_ALU_DEC;  o_alu_src  = 1'b1; o_kind = K_ALU; end
                c_OP_SLL:   begin w_alu = c_ALU_SLL;  o_alu_src  = 1'b1; o_kind = K_ALU; end
                c_OP_SRL:   begin w_alu = c_ALU_SRL;  o_alu_src  = 1'b1; o_kind = K_ALU; end
                c_OP_LWI:   begin w_alu = c_ALU_PASS; o_alu_src  = 1'b1; o_kind = K_ALU; end
                c_OP_LW:    begin w_alu = c_ALU_PASS; o_alu_src  = 1'b1; o_kind = K_LOAD; end
                c_OP_SW:    begin o_alu_src = 1'b1; o_kind = K_STORE; end
                c_OP_IN:    begin w_alu = c_ALU_PASS; o_kind = K_IN; end
                c_OP_BEQ:   o_kind = K_BEQ;
                c_OP_BNE:   o_kind = K_BNE;
                c_OP_JUMP:  o_kind = K_JUMP;
                c_OP_OUT:   o_kind = K_OUT;
                c_OP_HALT:  o_kind = K_HALT;
                c_OP_RESET: o_kind = K_RESET;
                default:    o_kind = K_ILLEGAL;
            endcase
        end
    end

    assign o_alu_op = ALUOP_W'(w_alu);

endmodule
`default_nettype wire

// File: rtl/multicycle_control.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_control
// Brief    : Multicycle CPU control FSM (FETCH/DECODE/EXEC/MEM/WB/WAIT_IN/HALT).
//            Define CU_IO_HANDSHAKE_EN to make WAIT_IN wait for in_valid.
// Revision : 1.0
// ============================================================================
module multicycle_control
    import cu_pkg::*;
#(
    parameter int OP_W    = 6,
    parameter int ALUOP_W = 4
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    multicycle_control_if.master  bus
);
    state_t             r_state;
    state_t             w_next;
    logic [OP_W-1:0]    r_opcode;

    logic [ALUOP_W-1:0] w_alu_op;
    logic               w_alu_src;
    logic               w_reg_dest;
    op_kind_t           w_kind;

    logic               w_write_reg, w_reg_dest_o, w_memto_reg, w_jump, w_in_signal;
    logic               w_alu_scr, w_write_en, w_read_en, w_branch, w_hlt, w_reset;
    logic               w_show, w_pc_write, w_ir_write, w_illegal;
    logic [ALUOP_W-1:0] w_alu_op_o;

    cu_alu_decode #(
        .OP_W    (OP_W),
        .ALUOP_W (ALUOP_W)
    ) u_alu_decode (
        .i_opcode   (r_opcode),
        .o_alu_op   (w_alu_op),
        .o_alu_src  (w_alu_src),
        .o_reg_dest (w_reg_dest),
        .o_kind     (w_kind)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= FETCH;
            r_opcode <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == DECODE) begin
                r_opcode <= bus.opcode;
            end
        end
    end

    always_comb begin
        w_next       = r_state;
        w_write_reg  = 1'b0;
        w_reg_dest_o = 1'b0;
        w_memto_reg  = 1'b0;
        w_jump       = 1'b0;
        w_in_signal  = 1'b0;
        w_alu_scr    = 1'b0;
        w_write_en   = 1'b0;
        w_read_en    = 1'b0;
        w_branch     = 1'b0;
        w_hlt        = 1'b0;
        w_reset      = 1'b0;
        w_show       = 1'b0;
        w_pc_write   = 1'b0;
        w_ir_write   = 1'b0;
        w_illegal    = 1'b0;
        w_alu_op_o   = '0;
        // Outputs are gated by rst_n so they clear the instant reset asserts
        if (rst_n) begin
            case (r_state)
                FETCH: begin
                    w_read_en = 1'b1;
                    if (bus.mem_ready) begin
                        w_ir_write = 1'b1;
                        w_pc_write = 1'b1;
                        w_next     = DECODE;
                    end
                end
                DECODE: w_next = EXEC;
                EXEC: begin
                    w_alu_op_o   = w_alu_op;
                    w_alu_scr    = w_alu_src;
                    w_reg_dest_o = w_reg_dest;
                    w_next       = FETCH;
                    case (w_kind)
                        K_ALU:   w_next = WB;
                        K_LOAD,
                        K_STORE: w_next = MEM;
                        K_IN:    w_next = WAIT_IN;
                        K_BEQ: begin
                            w_branch   = bus.zero;
                            w_pc_write = bus.zero;
                        end
                        K_BNE: begin
                            w_branch   = ~bus.zero;
                            w_pc_write = ~bus.zero;
                        end
                        K_JUMP: begin
                            w_jump     = 1'b1;
                            w_pc_write = 1'b1;
                        end
                        K_OUT:   w_show  = 1'b1;
                        K_RESET: w_reset = 1'b1;
                        K_HALT:  w_next  = HALT;
                        default: w_illegal = 1'b1;
                    endcase
                end
                MEM: begin
                    if (w_kind == K_LOAD) begin
                        w_read_en = 1'b1;
                    end else begin
                        w_write_en = 1'b1;
                    end
                    if (bus.mem_ready) begin
                        w_next = (w_kind == K_LOAD) ? WB : FETCH;
                    end
                end
                WB: begin
                    w_write_reg = 1'b1;
                    w_memto_reg = (w_kind == K_LOAD);
                    // Input word keeps the write-back mux pointed at the port
                    w_in_signal = (w_kind == K_IN);
                    w_next      = FETCH;
                end
                WAIT_IN: begin
                    w_in_signal = 1'b1;
`ifdef CU_IO_HANDSHAKE_EN
                    if (bus.in_valid) begin
                        w_next = WB;
                    end
`else
                    w_next = WB;
`endif
                end
                HALT: begin
                    w_hlt = 1'b1;
                    if (bus.resume) begin
                        w_next = FETCH;
                    end
                end
                default: w_next = FETCH;
            endcase
        end
    end

    assign bus.cu_writeReg    = w_write_reg;
    assign bus.cu_regDest     = w_reg_dest_o;
    assign bus.cu_memtoReg    = w_memto_reg;
    assign bus.cu_Jump        = w_jump;
    assign bus.cu_inSignal    = w_in_signal;
    assign bus.cu_aluScr      = w_alu_scr;
    assign bus.cu_writeEnable = w_write_en;
    assign bus.cu_readEnable  = w_read_en;
    assign bus.cu_Branch      = w_branch;
    assign bus.cu_hlt         = w_hlt;
    assign bus.cu_reset       = w_reset;
    assign bus.cu_showDisplay = w_show;
    assign bus.cu_pcWrite     = w_pc_write;
    assign bus.cu_irWrite     = w_ir_write;
    assign bus.cu_illegal     = w_illegal;
    assign bus.cu_aluOp       = w_alu_op_o;
    assign bus.cu_state       = r_state;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control.sv
`default_nettype none
// ============================================================================
// Module   : tb_multicycle_control
// Brief    : Directed-vector scoreboard bench for multicycle_control.
// Revision : 1.0
// ============================================================================
module tb_multicycle_control;

    localparam logic [14:0] PC   = 15'h0001;
    localparam logic [14:0] IR   = 15'h0002;
    localparam logic [14:0] RE   = 15'h0004;
    localparam logic [14:0] WE   = 15'h0008;
    localparam logic [14:0] WR   = 15'h0010;
    localparam logic [14:0] M2R  = 15'h0020;
    localparam logic [14:0] BR   = 15'h0040;
    localparam logic [14:0] JP   = 15'h0080;
    localparam logic [14:0] INS  = 15'h0100;
    localparam logic [14:0] HLT  = 15'h0200;
    localparam logic [14:0] RST  = 15'h0400;
    localparam logic [14:0] SHOW = 15'h0800;
    localparam logic [14:0] ILL  = 15'h1000;
    localparam logic [14:0] RD   = 15'h2000;
    localparam logic [14:0] AS   = 15'h4000;

    typedef struct packed {
        logic [2:0]  st;
        logic [14:0] fl;
        logic [3:0]  alu;
    } exp_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;
    exp_t exp_q[$];

    multicycle_control_if #(.OP_W(6), .ALUOP_W(4)) bus ();

    multicycle_control #(.OP_W(6), .ALUOP_W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: one expected record per cycle, sampled mid-cycle
    initial begin
        exp_t        e;
        logic [14:0] act;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                act = {bus.cu_aluScr, bus.cu_regDest, bus.cu_illegal, bus.cu_showDisplay,
                       bus.cu_reset, bus.cu_hlt, bus.cu_inSignal, bus.cu_Jump, bus.cu_Branch,
                       bus.cu_memtoReg, bus.cu_writeReg, bus.cu_writeEnable,
                       bus.cu_readEnable, bus.cu_irWrite, bus.cu_pcWrite};
                checks++;
                if (bus.cu_state !== e.st || act !== e.fl || bus.cu_aluOp !== e.alu) begin
                    failures++;
                    $display("FAIL cycle_check t=%0t: state=%0d flags=%h aluOp=%0d, expected state=%0d flags=%h aluOp=%0d",
                             $time, bus.cu_state, act, bus.cu_aluOp, e.st, e.fl, e.alu);
                end
            end
        end
    end

    task automatic step(input logic r, input logic [5:0] op, input logic z, input logic mr,
                        input logic iv, input logic rs, input logic [2:0] st,
                        input logic [14:0] fl, input logic [3:0] alu);
        exp_t e;
        rst_n         = r;
        bus.opcode    = op;
        bus.zero      = z;
        bus.mem_ready = mr;
        bus.in_valid  = iv;
        bus.resume    = rs;
        e.st  = st;
        e.fl  = fl;
        e.alu = alu;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic fetch_ok();
        step(1, 6'h00, 0, 1, 0, 0, 3'd0, RE | IR | PC, 4'd0);
    endtask

    task automatic decode(input logic [5:0] op);
        step(1, op, 0, 0, 0, 0, 3'd1, 15'h0, 4'd0);
    endtask

    task automatic exec(input logic z, input logic [14:0] fl, input logic [3:0] alu);
        step(1, 6'h00, z, 0, 0, 0, 3'd2, fl, alu);
    endtask

    initial begin
        checks = 0; failures = 0;
        rst_n = 1'b0;
        bus.opcode = '0; bus.zero = 0; bus.mem_ready = 0; bus.in_valid = 0; bus.resume = 0;
        @(posedge clk);
        #1;

        // Reset: everything zero even with mem_ready high
        step(0, 6'h00, 0, 0, 0, 0, 3'd0, 15'h0, 4'd0);
        step(0, 6'h00, 0, 1, 0, 0, 3'd0, 15'h0, 4'd0);
        step(1, 6'h00, 0, 0, 0, 0, 3'd0, RE, 4'd0);

        // add: 0,1,2,4
        fetch_ok(); decode(6'h00); exec(0, RD, 4'd1);
        step(1, 6'h00, 0, 0, 0, 0, 3'd4, WR, 4'd0);

        // slt and addi
        fetch_ok(); decode(6'h05); exec(0, RD, 4'd11);
        step(1, 6'h00, 0, 0, 0, 0, 3'd4, WR, 4'd0);
        fetch_ok(); decode(6'h0B); exec(0, AS, 4'd1);
        step(1, 6'h00, 0, 0, 0, 0, 3'd4, WR, 4'd0);

        // lw with two mem wait cycles: 7 cycles
        fetch_ok(); decode(6'h0F); exec(0, AS, 4'd15);
        step(1, 6'h00, 0, 0, 0, 0, 3'd3, RE, 4'd0);
        step(1, 6'h00, 0, 0, 0, 0, 3'd3, RE, 4'd0);
        step(1, 6'h00, 0, 1, 0, 0, 3'd3, RE, 4'd0);
        step(1, 6'h00, 0, 0, 0, 0, 3'd4, WR | M2R, 4'd0);

        // sw no wait: 4 cycles
        fetch_ok(); decode(6'h10); exec(0, AS, 4'd0);
        step(1, 6'h00, 0, 1, 0, 0, 3'd3, WE, 4'd0);

        // beq / bne
        fetch_ok(); decode(6'h09); exec(1, BR | PC, 4'd0);
        fetch_ok(); decode(6'h09); exec(0, 15'h0, 4'd0);
        fetch_ok(); decode(6'h0A); exec(1, 15'h0, 4'd0);
        fetch_ok(); decode(6'h0A); exec(0, BR | PC, 4'd0);

        // jump, out, reset opcode
        fetch_ok(); decode(6'h17); exec(0, JP | PC, 4'd0);
        fetch_ok(); decode(6'h16); exec(0, SHOW, 4'd0);
        fetch_ok(); decode(6'h19); exec(0, RST, 4'd0);

        // halt held 10 cycles, resume leaves next cycle
        fetch_ok(); decode(6'h18); exec(0, 15'h0, 4'd0);
        for (int i = 0; i < 10; i++) step(1, 6'h00, 0, 1, 0, 0, 3'd6, HLT, 4'd0);
        step(1, 6'h00, 0, 0, 0, 1, 3'd6, HLT, 4'd0);
        step(1, 6'h00, 0, 0, 0, 0, 3'd0, RE, 4'd0);

        // in
        fetch_ok(); decode(6'h15); exec(0, 15'h0, 4'd15);
`ifdef CU_IO_HANDSHAKE_EN
        step(1, 6'h00, 0, 0, 0, 0, 3'd5, INS, 4'd0);
        step(1, 6'h00, 0, 0, 0, 0, 3'd5, INS, 4'd0);
        step(1, 6'h00, 0, 0, 0, 0, 3'd5, INS, 4'd0);
        step(1, 6'h00, 0, 0, 1, 0, 3'd5, INS, 4'd0);
`else
        step(1, 6'h00, 0, 0, 1, 0, 3'd5, INS, 4'd0);
`endif
        step(1, 6'h00, 0, 0, 0, 0, 3'd4, WR | INS, 4'd0);

        // illegal opcode: single pulse, no writes
        fetch_ok(); decode(6'h3F); exec(0, ILL, 4'd0);
        step(1, 6'h00, 0, 0, 0, 0, 3'd0, RE, 4'd0);

        // sw interrupted by reset mid-MEM
        fetch_ok(); decode(6'h10); exec(0, AS, 4'd0);
        step(1, 6'h00, 0, 0, 0, 0, 3'd3, WE, 4'd0);
        step(0, 6'h00, 0, 0, 0, 0, 3'd0, 15'h0, 4'd0);
        step(1, 6'h00, 0, 0, 0, 0, 3'd0, RE, 4'd0);
        fetch_ok();
        step(1, 6'h00, 0, 0, 0, 0, 3'd1, 15'h0, 4'd0);

        repeat (2) @(negedge clk);
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d records left, expected 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
